// File: rtl/ysyx_24100005_fetch_ctrl.sv
// ysyx_24100005_fetch_ctrl
//
// Multi-cycle fetch/execute sequencer placed in front of a single-cycle core
// datapath. It issues a fetch at the current PC over a valid/ready
// instruction-memory port and latches the returned word. It then presents that
// word to the decoder for exactly one execute cycle, and only in that cycle
// enables the PC and register-file writes. An ebreak retires into a sticky halt.
// Non-ebreak instructions are counted as they retire.
//
// Optional feature: define YSYX_24100005_FETCH_WATCHDOG_EN to build a 16-bit
// fetch watchdog. When it expires, the controller moves to a sticky error state.
//
// Parameters:
//   TIMEOUT          fetch watchdog limit in cycles (1..65535), watchdog builds only
// Ports:
//   clk, rst         core clock, asynchronous active-high reset
//   pc               current PC from the PC register
//   imem_req_*       fetch request channel (valid/ready, address)
//   imem_resp_*      fetch response channel (valid/ready, data)
//   inst, inst_valid latched instruction and its execute-cycle qualifier
//   pc_wen           PC register write enable (execute cycle, non-ebreak)
//   rf_wen_en        gating term for the datapath register-file write enable
//   halt, err        sticky ebreak-retired / watchdog-expired flags
//   retire_cnt       number of retired non-ebreak instructions

module ysyx_24100005_fetch_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        imem_resp_ready,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic        pc_wen,
   output logic        rf_wen_en,
   output logic        halt,
   output logic        err,
   output logic [31:0] retire_cnt
);

   typedef enum logic [2:0] {
      StIdle,
      StFreq,
      StFwait,
      StExec,
      StHalt,
      StErr
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] retire_q, retire_d;
   logic        is_ebreak;

   // Only the opcode is decoded; every SYSTEM-opcode instruction stops the core.
   assign is_ebreak = (inst_q[6:0] == 7'b1110011);

`ifdef YSYX_24100005_FETCH_WATCHDOG_EN
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

   logic [15:0] wd_q, wd_d;
   logic        fetching;
   logic        resp_hs;

   assign fetching = (state_q == StFreq) || (state_q == StFwait);
   assign resp_hs  = (state_q == StFwait) && imem_resp_valid;
`else
   // The limit only matters when the watchdog is built.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   always_comb begin
      state_d  = state_q;
      inst_d   = inst_q;
      retire_d = retire_q;
      case (state_q)
         StIdle:  state_d = StFreq;
         StFreq:  if (imem_req_ready) state_d = StFwait;
         StFwait: begin
            if (imem_resp_valid) begin
               inst_d  = imem_resp_data;
               state_d = StExec;
            end
         end
         StExec: begin
            if (is_ebreak) begin
               state_d = StHalt;
            end else begin
               retire_d = retire_q + 32'd1;
               state_d  = StFreq;
            end
         end
         StHalt:  state_d = StHalt;
         StErr:   state_d = StErr;
         default: state_d = StIdle;
      endcase

`ifdef YSYX_24100005_FETCH_WATCHDOG_EN
      // The last allowed cycle has passed. A response taken in that same cycle still wins.
      if (fetching && (wd_q == TimeoutLast) && !resp_hs) begin
         state_d = StErr;
      end

      wd_d = wd_q;
      if ((state_d == StFreq) && (state_q != StFreq)) begin
         wd_d = '0;
      end else if (fetching) begin
         wd_d = wd_q + 16'd1;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         inst_q   <= '0;
         retire_q <= '0;
`ifdef YSYX_24100005_FETCH_WATCHDOG_EN
         wd_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         inst_q   <= inst_d;
         retire_q <= retire_d;
`ifdef YSYX_24100005_FETCH_WATCHDOG_EN
         wd_q     <= wd_d;
`endif
      end
   end

   // Every output is decoded from registered state only, so it cannot glitch on memory inputs.
   assign imem_req_valid  = (state_q == StFreq);
   assign imem_req_addr   = (state_q == StFreq) ? pc : 32'd0;
   assign imem_resp_ready = (state_q == StFwait);
   assign inst            = inst_q;
   assign inst_valid      = (state_q == StExec);
   assign pc_wen          = (state_q == StExec) && !is_ebreak;
   assign rf_wen_en       = (state_q == StExec) && !is_ebreak;
   assign halt            = (state_q == StHalt);
   assign retire_cnt      = retire_q;

`ifdef YSYX_24100005_FETCH_WATCHDOG_EN
   assign err = (state_q == StErr);
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24100005_fetch_ctrl.sv
// Scoreboard bench for ysyx_24100005_fetch_ctrl. The directed stimulus pushes the
// expected fetch addresses and execute-cycle results into queues. A monitor pops
// those entries and compares them whenever the DUT completes a request handshake
// or asserts inst_valid.
module tb_ysyx_24100005_fetch_ctrl;

   localparam logic [31:0] Base   = 32'h8000_0000;
   localparam logic [31:0] Addi   = 32'h0010_0093;
   localparam logic [31:0] Ebreak = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid, imem_resp_ready;
   logic [31:0] imem_resp_data;
   logic [31:0] inst, retire_cnt;
   logic        inst_valid, pc_wen, rf_wen_en, halt, err;

   always #5 clk = ~clk;

   ysyx_24100005_fetch_ctrl #(.TIMEOUT(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .imem_resp_ready(imem_resp_ready),
      .inst           (inst),
      .inst_valid     (inst_valid),
      .pc_wen         (pc_wen),
      .rf_wen_en      (rf_wen_en),
      .halt           (halt),
      .err            (err),
      .retire_cnt     (retire_cnt)
   );

   typedef struct packed {
      logic [31:0] inst;
      logic        wen;
      logic [31:0] retire;
   } exec_t;

   logic [31:0] exp_addr[$];
   exec_t       exp_exec[$];
   int          n_vec = 0;
   int          n_miss = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // ---------------- memory model ----------------
   logic [31:0] mem[logic [31:0]];
   int          req_wait = 0, resp_wait = 0;
   bit          silent = 0, force_resp = 0;
   bit          pend = 0, hs_req = 0, hs_resp = 0, pc_step = 0;
   int          req_cnt = 0, resp_cnt = 0;
   logic [31:0] lat_addr = '0;
   // Values sampled at the negedge for the handshake or execute on the next posedge.
   bit          s_req_hs = 0, s_exec = 0, s_pc_wen = 0, s_rf = 0;
   logic [31:0] s_addr = '0, s_inst = '0, s_retire = '0;

   function automatic logic [31:0] rd(logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0000_0013;
   endfunction

   initial begin
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 0; hs_req = 0; hs_resp = 0; pc_step = 0;
            s_req_hs = 0; s_exec = 0;
            req_cnt = req_wait;
            imem_req_ready  = 1'b0;
            imem_resp_valid = force_resp;
            imem_resp_data  = force_resp ? 32'hdead_beef : 32'd0;
         end else begin
            if (hs_resp) pend = 0;
            if (hs_req) begin
               pend = 1;
               resp_cnt = resp_wait;
            end
            pc_step  = pc_wen;
            s_exec   = inst_valid;
            s_inst   = inst;
            s_pc_wen = pc_wen;
            s_rf     = rf_wen_en;
            s_retire = retire_cnt;
            if (imem_req_valid) begin
               if (req_cnt > 0) begin
                  imem_req_ready = 1'b0;
                  req_cnt--;
               end else begin
                  imem_req_ready = 1'b1;
               end
            end else begin
               imem_req_ready = 1'b0;
               req_cnt = req_wait;
            end
            hs_req = imem_req_valid && imem_req_ready;
            if (hs_req) lat_addr = imem_req_addr;
            s_req_hs = hs_req;
            s_addr   = imem_req_addr;
            if (pend && !silent) begin
               if (resp_cnt > 0) begin
                  imem_resp_valid = 1'b0;
                  resp_cnt--;
               end else begin
                  imem_resp_valid = 1'b1;
                  imem_resp_data  = rd(lat_addr);
               end
            end else begin
               imem_resp_valid = 1'b0;
               imem_resp_data  = '0;
            end
            hs_resp = imem_resp_valid && imem_resp_ready;
         end
      end
   end

   // PC register model: step by 4 on the edge that ends a pc_wen cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst && pc_step) pc = pc + 32'd4;
      end
   end

   // ---------------- monitor ----------------
   initial begin
      exec_t e;
      forever begin
         @(posedge clk);
         if (s_req_hs) begin
            if (exp_addr.size() == 0) begin
               n_vec++; n_miss++;
               $display("FAIL unexpected_req: got addr %h expected none", s_addr);
            end else begin
               chk("req_addr", s_addr, exp_addr.pop_front());
            end
         end
         if (s_exec) begin
            if (exp_exec.size() == 0) begin
               n_vec++; n_miss++;
               $display("FAIL unexpected_exec: got inst %h expected none", s_inst);
            end else begin
               e = exp_exec.pop_front();
               chk("exec_inst", s_inst, e.inst);
               chk("exec_pc_wen", 32'(s_pc_wen), 32'(e.wen));
               chk("exec_rf_wen_en", 32'(s_rf), 32'(e.wen));
               chk("exec_retire_cnt", s_retire, e.retire);
            end
         end
      end
   end

   task automatic check_zero(string tag);
      chk({tag, "_req_valid"}, 32'(imem_req_valid), 0);
      chk({tag, "_req_addr"}, imem_req_addr, 0);
      chk({tag, "_resp_ready"}, 32'(imem_resp_ready), 0);
      chk({tag, "_inst"}, inst, 0);
      chk({tag, "_inst_valid"}, 32'(inst_valid), 0);
      chk({tag, "_pc_wen"}, 32'(pc_wen), 0);
      chk({tag, "_rf_wen_en"}, 32'(rf_wen_en), 0);
      chk({tag, "_halt"}, 32'(halt), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_retire_cnt"}, retire_cnt, 0);
   endtask

   task automatic release_rst();
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic assert_rst();
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int first_exec, e_ret, e_halt, e_err, n_req, addr_bad, early_wen, req_after;
      pc = Base;
      for (int i = 0; i < 10; i++) mem[Base + 32'(4 * i)] = Addi;
      mem[Base + 32'd40] = Ebreak;

      // Reset state
      repeat (2) @(posedge clk);
      #1 check_zero("reset");

      // 10 addi then ebreak, zero-wait memory
      for (int i = 0; i <= 10; i++) exp_addr.push_back(Base + 32'(4 * i));
      for (int i = 0; i < 10; i++) exp_exec.push_back('{inst: Addi, wen: 1'b1, retire: 32'(i)});
      exp_exec.push_back('{inst: Ebreak, wen: 1'b0, retire: 32'd10});
      release_rst();
      first_exec = 0; e_ret = 0; e_halt = 0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (e == 1) begin
            chk("first_req_valid", 32'(imem_req_valid), 1);
            chk("first_req_addr", imem_req_addr, Base);
         end
         if (e == 4) chk("retire_after_first", retire_cnt, 1);
         if (inst_valid && first_exec == 0) first_exec = e;
         if (retire_cnt == 32'd10 && e_ret == 0) e_ret = e;
         if (halt && e_halt == 0) e_halt = e;
      end
      chk("first_exec_cycle", first_exec, 3);
      chk("ten_retired_cycle", e_ret, 31);
      chk("halt_cycle", e_halt, 34);
      n_req = 0;
      for (int e = 0; e < 100; e++) begin
         @(negedge clk);
         if (imem_req_valid) n_req++;
      end
      chk("req_after_halt", n_req, 0);
      chk("halt_sticky", 32'(halt), 1);
      chk("retire_after_halt", retire_cnt, 10);
      chk("inst_held", inst, Ebreak);
      chk("queue_addr_empty_1", exp_addr.size(), 0);
      chk("queue_exec_empty_1", exp_exec.size(), 0);

      // Request stalled 4 cycles, response stalled 3 cycles
      assert_rst();
      pc = Base; req_wait = 4; resp_wait = 3;
      exp_addr.push_back(Base);
      exp_exec.push_back('{inst: Addi, wen: 1'b1, retire: 32'd0});
      release_rst();
      n_req = 0; addr_bad = 0; early_wen = 0; first_exec = 0;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (imem_req_valid) begin
            n_req++;
            if (imem_req_addr !== Base) addr_bad++;
         end
         if ((pc_wen || rf_wen_en) && !inst_valid) early_wen++;
         if (inst_valid && first_exec == 0) first_exec = e;
      end
      chk("stall_req_cycles", n_req, 5);
      chk("stall_addr_changes", addr_bad, 0);
      chk("stall_exec_cycle", first_exec, 10);
      chk("stall_early_wen", early_wen, 0);
      assert_rst();
      chk("queue_addr_empty_2", exp_addr.size(), 0);
      chk("queue_exec_empty_2", exp_exec.size(), 0);

      // Memory accepts the request but never responds
      pc = Base; req_wait = 0; resp_wait = 0; silent = 1;
      exp_addr.push_back(Base);
      release_rst();
      e_err = 0; req_after = 0;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (err && e_err == 0) e_err = e;
         if (e_err != 0 && imem_req_valid) req_after++;
      end
`ifdef YSYX_24100005_FETCH_WATCHDOG_EN
      chk("wd_err_cycle", e_err, 9);
      chk("wd_req_after_err", req_after, 0);
      chk("wd_resp_ready", 32'(imem_resp_ready), 0);
`else
      chk("nowd_err_cycle", e_err, 0);
      chk("nowd_still_waiting", 32'(imem_resp_ready), 1);
`endif
      assert_rst();
      silent = 0;
      chk("queue_addr_empty_3", exp_addr.size(), 0);

      // Reset in FWAIT while a response is in flight
      pc = Base; resp_wait = 3;
      exp_addr.push_back(Base);
      release_rst();
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      force_resp = 1;
      #1 check_zero("midfetch");
      repeat (3) @(posedge clk);
      force_resp = 0; resp_wait = 0;
      exp_addr.push_back(Base);
      exp_exec.push_back('{inst: Addi, wen: 1'b1, retire: 32'd0});
      release_rst();
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (e == 1) begin
            chk("abort_inst_clear", inst, 0);
            chk("abort_req_addr", imem_req_addr, Base);
         end
         if (e == 3) begin
            chk("abort_exec_valid", 32'(inst_valid), 1);
            chk("abort_exec_inst", inst, Addi);
         end
      end
      assert_rst();
      repeat (2) @(posedge clk);
      chk("queue_addr_empty_4", exp_addr.size(), 0);
      chk("queue_exec_empty_4", exp_exec.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #200000;
      n_vec++; n_miss++;
      $display("FAIL timeout: got no finish expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ysyx_24100005_fetch_ctrl.md
# ysyx_24100005_fetch_ctrl

Multi-cycle sequencer that turns the single-cycle core datapath into a fetch/execute machine behind a valid/ready instruction-memory port. It issues a fetch at the current PC, waits for the response, presents the latched instruction to the decoder for exactly one execute cycle, and only then enables the PC and register-file writes. It also retires ebreak into a sticky halt and counts retired instructions.

## Interface
Parameters:
- TIMEOUT, 255: fetch watchdog limit in cycles; legal range 1..65535. Used only when the watchdog is compiled in.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- pc  in  32  current PC from the PC register
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address
- imem_req_ready  in  1  memory accepts the request
- imem_resp_valid  in  1  instruction data valid
- imem_resp_data  in  32  instruction word
- imem_resp_ready  out  1  controller accepts the response
- inst  out  32  latched instruction, feeds the decoder
- inst_valid  out  1  high during the execute cycle
- pc_wen  out  1  PC register write enable
- rf_wen_en  out  1  AND-gate term applied to the datapath's register-file wen
- halt  out  1  sticky; ebreak retired
- err  out  1  sticky; fetch watchdog expired (constant 0 when the watchdog is compiled out)
- retire_cnt  out  32  number of retired non-ebreak instructions

## Operation
- States: IDLE, FREQ, FWAIT, EXEC, HALT, ERR.
- IDLE: entered on reset. All outputs are 0. Always goes to FREQ on the next edge.
- FREQ:
  - imem_req_valid=1 and imem_req_addr=pc. pc is stable here because pc_wen=0.
  - On imem_req_ready=1, go to FWAIT.
- FWAIT:
  - imem_resp_ready=1.
  - On imem_resp_valid=1, latch imem_resp_data into inst and go to EXEC.
  - A response is never taken in FREQ. Memory must return data no earlier than the cycle after acceptance.
- EXEC:
  - inst_valid=1.
  - If inst[6:0]==7'b1110011 (ebreak): pc_wen=0 and rf_wen_en=0, go to HALT, retire_cnt unchanged.
  - Otherwise: pc_wen=1, rf_wen_en=1, retire_cnt increments by 1 (wraps 0xFFFFFFFF→0), go to FREQ.
- HALT: terminal. halt=1. No further requests. inst is held. Left only by rst.
- ERR: terminal. err=1. No requests. Left only by rst.
- inst holds its value outside EXEC; it changes only on a response handshake in FWAIT.
- imem_req_valid, once raised in FREQ, stays high with constant address until ready. The controller never withdraws a request.

## Timing
- Reset (async assert, sync release to the next edge): state=IDLE, inst=0, retire_cnt=0, and every output is 0.
- With zero-wait memory (ready and resp_valid high continuously), steady state is 3 cycles per instruction: FREQ → FWAIT → EXEC. The first FREQ occurs 1 cycle after reset release (IDLE).
- Each added request wait cycle and each response wait cycle adds one cycle.
- pc_wen and rf_wen_en are single-cycle pulses, coincident with inst_valid. The PC updates on the edge that ends EXEC.
- Reset mid-fetch aborts the transaction; any in-flight response is dropped (imem_resp_ready=0 outside FWAIT). The memory model is reset together with the core.
- halt and err rise on the edge leaving EXEC or FWAIT respectively, then stay high.

## Configuration
- YSYX_24100005_FETCH_WATCHDOG_EN defined:
  - A 16-bit counter clears on entry to FREQ and increments each cycle in FREQ or FWAIT.
  - When it reaches TIMEOUT without a completed response handshake, the next state is ERR.
  - A completed handshake in the same cycle wins over the timeout.
- Undefined: no counter and no ERR state; err is tied to 0 and fetch waits indefinitely.

## Test plan
- Reset release with zero-wait memory returning addi (0x00100093) at 0x80000000 → req at 0x80000000 one cycle after release; inst_valid/pc_wen/rf_wen_en pulse on the 3rd cycle; retire_cnt=1.
- Stream of 10 addi with zero-wait memory → exactly 30 cycles from first FREQ to the 10th EXEC exit; retire_cnt=10; imem_req_addr follows pc.
- imem_req_ready held low 4 cycles, resp_valid delayed 3 cycles → request held stable with constant addr for 5 cycles; EXEC at cycle 1+5+4; no pc_wen before EXEC.
- ebreak (0x00100073) fetched → inst_valid=1 with pc_wen=0 and rf_wen_en=0; halt=1 next cycle; no further req_valid for 100 cycles; retire_cnt unchanged.
- Watchdog enabled, TIMEOUT=8, memory never responds → err=1 after 8 cycles in FREQ/FWAIT, req_valid=0 thereafter. With the watchdog compiled out, the same stimulus keeps waiting with err=0.
- rst asserted in FWAIT, then response pulsed → outputs 0 immediately (asynchronous); response ignored; a clean fetch at pc follows release.
